// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: forwards core fetch requests to memory under a credit limit,
// buffers responses in a DEPTH-entry FIFO and returns them in order. A flush empties the
// FIFO and discards any responses still in flight, while new fetches continue to be accepted.
//
// Optional feature: define INSTR_FETCH_BUF_ERR_EN to store the bus error bit alongside each
// word and return it on core_err_o; otherwise mem_err_i is ignored and core_err_o is 0.
//
// Ports:
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   flush_i                   drop all buffered and in-flight fetches
//   core_req_i/core_gnt_o     core request / accept, core_addr_i fetch address
//   core_rvalid_o/core_rready_i, core_rdata_o, core_err_o   core response channel
//   mem_req_o/mem_gnt_i, mem_addr_o                        memory request channel
//   mem_rvalid_i, mem_rdata_i, mem_err_i                   memory response (no back-pressure)
//   outstanding_o             requests granted but not yet answered (debug)
module instr_fetch_buffer #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  input  logic                       core_req_i,
  output logic                       core_gnt_o,
  input  logic [ADDR_W-1:0]          core_addr_i,
  output logic                       core_rvalid_o,
  input  logic                       core_rready_i,
  output logic [DATA_W-1:0]          core_rdata_o,
  output logic                       core_err_o,
  output logic                       mem_req_o,
  input  logic                       mem_gnt_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_rvalid_i,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  input  logic                       mem_err_i,
  output logic [$clog2(DEPTH):0]     outstanding_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
`ifdef INSTR_FETCH_BUF_ERR_EN
  localparam int unsigned EntryW = DATA_W + 1;
`else
  localparam int unsigned EntryW = DATA_W;
`endif

  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [CntW-1:0]   discard_q, discard_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [EntryW-1:0] store_q [DEPTH];

  logic [CntW:0]     used;
  logic              credit_ok;
  logic              grant;
  logic              push;
  logic              pop;
  logic              drop;
  logic [EntryW-1:0] entry_in;
  logic [EntryW-1:0] head;

  // Every granted request reserves a FIFO slot, so a response can never find the FIFO full.
  assign used      = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok = used < (CntW + 1)'(DEPTH);

  assign mem_addr_o = core_addr_i;
  // Gated by rstn_i so the request path is quiet while reset is held.
  assign mem_req_o  = rstn_i & core_req_i & ~flush_i & credit_ok;
  assign core_gnt_o = mem_req_o & mem_gnt_i;
  assign grant      = core_gnt_o;

  // Responses owed to fetches issued before a flush are dropped until discard drains.
  assign drop = mem_rvalid_i & ~flush_i & (discard_q != '0);
  assign push = mem_rvalid_i & ~flush_i & (discard_q == '0);
  assign pop  = core_rvalid_o & core_rready_i & ~flush_i;

`ifdef INSTR_FETCH_BUF_ERR_EN
  assign entry_in = {mem_err_i, mem_rdata_i};
`else
  assign entry_in = mem_rdata_i;
  logic unused_mem_err;
  assign unused_mem_err = mem_err_i;
`endif

  always_comb begin
    inflight_d = inflight_q;
    unique case ({grant, mem_rvalid_i})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase

    discard_d = discard_q;
    if (flush_i) begin
      // A response arriving in the flush cycle itself is already gone.
      discard_d = inflight_q - CntW'(mem_rvalid_i);
    end else if (drop) begin
      discard_d = discard_q - CntW'(1);
    end

    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush_i) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else if (push) begin
      store_q[wptr_q] <= entry_in;
    end
  end

  assign head          = store_q[rptr_q];
  assign core_rvalid_o = (count_q != '0);
  assign core_rdata_o  = core_rvalid_o ? head[DATA_W-1:0] : '0;
`ifdef INSTR_FETCH_BUF_ERR_EN
  assign core_err_o    = core_rvalid_o & head[DATA_W];
`else
  assign core_err_o    = 1'b0;
`endif

  assign outstanding_o = inflight_q;

endmodule

// File: doc/instr_fetch_buffer.md
INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameters, one per line, as name, default, meaning:
  ADDR_W, 32, fetch address width
  DATA_W, 32, instruction word width
  DEPTH, 4, maximum responses in flight plus buffered (power of 2, >=2)
REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
  clk_i  in  1  single clock, all state on rising edge
  rstn_i  in  1  asynchronous active-low reset
  flush_i  in  1  discard all in-flight and buffered fetches
  core_req_i  in  1  tile instruction fetch request
  core_gnt_o  out  1  request accepted
  core_addr_i  in  ADDR_W  fetch address
  core_rvalid_o  out  1  response word valid
  core_rready_i  in  1  tile accepts response
  core_rdata_o  out  DATA_W  instruction word
  core_err_o  out  1  bus error on this word
  mem_req_o  out  1  memory-side request
  mem_gnt_i  in  1  memory grant
  mem_addr_o  out  ADDR_W  memory-side address
  mem_rvalid_i  in  1  memory response valid (no back-pressure)
  mem_rdata_i  in  DATA_W  memory response data
  mem_err_i  in  1  memory response error
  outstanding_o  out  $clog2(DEPTH)+1  in-flight count, debug
REQ-003 SHALL place rstn_i in the sensitivity of every flop as an asynchronous active-low reset, with clk_i as the only clock.

Function
REQ-004 SHALL forward requests combinationally: mem_addr_o = core_addr_i; mem_req_o = core_req_i & ~flush_i & (inflight + count < DEPTH); core_gnt_o = mem_req_o & mem_gnt_i.
REQ-005 SHALL increment inflight on mem_req_o&mem_gnt_i and decrement it on mem_rvalid_i; when both occur in the same cycle, inflight SHALL stay unchanged.
REQ-006 SHALL push {mem_err_i, mem_rdata_i} into a DEPTH-entry FIFO on mem_rvalid_i unless the response is being discarded (REQ-009). The credit rule in REQ-004 guarantees that a push never finds the FIFO full.
REQ-007 SHALL drive core_rvalid_o = FIFO not empty and present the head entry from registers, giving 1-cycle latency from mem_rvalid_i to core_rvalid_o. The FIFO SHALL pop on core_rvalid_o&core_rready_i.
REQ-008 SHALL allow a push and a pop in the same cycle, including when count = DEPTH-1, with count unchanged. Read and write pointers SHALL wrap modulo DEPTH.
REQ-009 On flush_i, the block SHALL:
  - clear the FIFO (count to 0, pointers equal) at the next edge;
  - load discard = inflight minus any mem_rvalid_i in that cycle;
  - drop the next `discard` responses, decrementing discard on each;
  - hold mem_req_o low during the flush cycle.
REQ-010 SHALL accept new requests while discard > 0, provided the credit rule holds (discard counts toward inflight). Responses arriving after discard reaches 0 SHALL be pushed normally, preserving order.
REQ-011 SHALL drive outstanding_o = inflight.

Reset
REQ-012 On rstn_i low, the block SHALL asynchronously set inflight, discard, count and both pointers to 0, and drive core_rvalid_o=0, core_rdata_o=0, core_err_o=0, mem_req_o=0, core_gnt_o=0.
REQ-013 Reset mid-transaction SHALL abandon all state. After reset, the first mem_rvalid_i not matched by a post-reset grant is a protocol violation and need not be handled.

Configuration
REQ-014 With macro INSTR_FETCH_BUF_ERR_EN defined, the FIFO SHALL be DATA_W+1 bits wide and core_err_o SHALL reflect the stored error bit of the head entry.
REQ-015 Without INSTR_FETCH_BUF_ERR_EN, the FIFO SHALL be DATA_W bits wide, mem_err_i SHALL be ignored and core_err_o SHALL be tied 0.

Verification (DEPTH=4)
REQ-016 Single fetch: addr 0x1C00_0000 granted at cycle 0, mem_rvalid_i with data 0x0000_0013 at cycle 2 -> core_rvalid_o=1 with data 0x13 at cycle 3.
REQ-017 Credit limit: core_rready_i=0, mem_gnt_i=1, four fetches granted -> mem_req_o=0 on the 5th request until one pop occurs, and outstanding_o+count never exceeds 4.
REQ-018 Simultaneous push and pop at count=3 -> count stays 3 and data order is preserved across pointer wrap, checked over 16 words 0..15.
REQ-019 Flush with 2 in flight and 1 buffered -> FIFO empty next cycle, the next 2 mem responses are dropped, and the 3rd (0xABCD) appears on core_rdata_o.
REQ-020 ERR_EN build: mem_err_i=1 on the 2nd of 3 responses -> core_err_o=1 only with the 2nd word. Non-ERR_EN build: core_err_o=0 throughout.
REQ-021 rstn_i asserted with 3 in flight -> all outputs 0 immediately and outstanding_o=0, and a fresh fetch afterward completes per REQ-016.
